// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload layouts and their bubble values.
package pipe_pkg;

  typedef logic [31:0] word_t;

  // IF/ID payload: fetched instruction plus its address and fall-through address.
  typedef struct packed {
    word_t instruction;
    word_t imemaddr;
    word_t next_imemaddr;
  } if_id_payload_t;

  localparam int IF_ID_W = $bits(if_id_payload_t);

  // An all-zero instruction decodes as a NOP, so an all-zero payload is a safe bubble.
  localparam if_id_payload_t PIPE_BUBBLE_IF_ID = '{
    instruction:   32'h0000_0000,
    imemaddr:      32'h0000_0000,
    next_imemaddr: 32'h0000_0000
  };

  // Further stage payload structs are added here as stages convert.

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; cleared only by reset.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance on inc unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush-to-bubble,
// occupancy status and saturating stall/flush counters.
//
// Handshake: a payload moves across an interface on every rising edge where
// valid and ready are both high. Valid, once raised, is held with stable data
// until accepted (or flushed). in_ready is a flop output (equal to !skid_valid)
// so no combinational path exists from out_ready back to in_ready; the skid
// entry absorbs the one payload that arrives while the stall propagates.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic enq;
  logic deq;

  assign enq = in_valid & ~skid_valid_q;
  assign deq = main_valid_q & out_ready;

  // Next-state for both entries: flush empties everything, otherwise the main
  // entry refills from skid first (FIFO order), then from the input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE;
    end else if (!main_valid_q || deq) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = enq;
        skid_data_d  = enq ? in_data : BUBBLE;
      end else begin
        main_valid_d = enq;
        main_data_d  = enq ? in_data : BUBBLE;
      end
    end else if (enq) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Entry registers; reset wins over flush and any handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_valid_q ? main_data_q : BUBBLE;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // A flushed cycle is not counted as a stall.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (main_valid_q & ~out_ready & ~flush),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule
